// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared definitions for the ID/EX pipeline latch: control bundle layout,
// the hard-wired zero register and the WB write-through match helper.
package id_ex_pipe_reg_pkg;

  localparam int CTRL_W = 8;

  localparam int CTRL_REG_WRITE  = 7;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_MEM_READ   = 5;
  localparam int CTRL_MEM_WRITE  = 4;
  localparam int CTRL_ALU_SRC    = 3;
  localparam int CTRL_ALU_OP_HI  = 2;
  localparam int CTRL_ALU_OP_LO  = 1;
  localparam int CTRL_REG_DST    = 0;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // $0 is hard-wired, so a WB write to it must never be forwarded.
  function automatic logic bypass_hit(input logic we, input logic [4:0] wb_addr,
                                      input logic [4:0] rd_addr);
    return we && (wb_addr != REG_ZERO) && (wb_addr == rd_addr);
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_sat_counter.sv
// Saturating event counter with synchronous active-high clear; sticks at
// all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != '1)) begin
      count_o <= count_o + CNT_ONE;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline latch: registers decoded control, operands, immediate and
// register specifiers, with hold, bubble insertion and WB write-through.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = id_ex_pipe_reg_pkg::CTRL_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [4:0]        rs_addr_i,
  input  logic [4:0]        rt_addr_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [4:0]        rs_addr_o,
  output logic [4:0]        rt_addr_o,
  output logic [4:0]        rd_addr_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  // Handshake: valid_o marks a real instruction in EX. There is no
  // back-pressure; stall_i holds the stage and flush_i replaces it with a
  // bubble (valid_o=0, everything else 0) on the same edge.
  logic              stall_evt;
  logic [DATA_W-1:0] rs_next;
  logic [DATA_W-1:0] rt_next;

  assign stall_evt = stall_i && !flush_i;

  always_comb begin
    rs_next = rs_data_i;
    rt_next = rt_data_i;
    if (bypass_hit(wb_we_i, wb_addr_i, rs_addr_i)) rs_next = wb_data_i;
    if (bypass_hit(wb_we_i, wb_addr_i, rt_addr_i)) rt_next = wb_data_i;
  end

  // Bubbles clear addresses too, so a bubble never matches the forwarding compare.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      valid_o   <= 1'b0;
      ctrl_o    <= '0;
      rs_data_o <= '0;
      rt_data_o <= '0;
      imm_o     <= '0;
      rs_addr_o <= REG_ZERO;
      rt_addr_o <= REG_ZERO;
      rd_addr_o <= REG_ZERO;
    end else if (!stall_i) begin
      valid_o   <= valid_i;
      ctrl_o    <= valid_i ? ctrl_i : '0;
      rs_data_o <= rs_next;
      rt_data_o <= rt_next;
      imm_o     <= imm_i;
      rs_addr_o <= rs_addr_i;
      rt_addr_o <= rt_addr_i;
      rd_addr_o <= rd_addr_i;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (stall_evt),
    .count_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (flush_i),
    .count_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed vectors push hand-computed expected
// output bundles; a monitor pops and compares after every active edge.
module tb_id_ex_pipe_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;
  localparam int W = 1 + CTRL_W + 3*DATA_W + 15 + 2*CNT_W;

  logic              clk = 1'b0;
  logic              rst, stall, flush, valid, wb_we;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] rs_data, rt_data, imm, wb_data;
  logic [4:0]        rs_addr, rt_addr, rd_addr, wb_addr;

  logic              valid_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0] rs_data_o, rt_data_o, imm_o;
  logic [4:0]        rs_addr_o, rt_addr_o, rd_addr_o;
  logic [CNT_W-1:0]  stall_cnt_o, flush_cnt_o;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  id_ex_pipe_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .valid_i(valid), .ctrl_i(ctrl), .rs_data_i(rs_data), .rt_data_i(rt_data),
    .imm_i(imm), .rs_addr_i(rs_addr), .rt_addr_i(rt_addr), .rd_addr_i(rd_addr),
    .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .valid_o(valid_o), .ctrl_o(ctrl_o), .rs_data_o(rs_data_o),
    .rt_data_o(rt_data_o), .imm_o(imm_o), .rs_addr_o(rs_addr_o),
    .rt_addr_o(rt_addr_o), .rd_addr_o(rd_addr_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive(input logic r, input logic s, input logic f, input logic v,
                       input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] rsd,
                       input logic [DATA_W-1:0] rtd, input logic [DATA_W-1:0] im,
                       input logic [4:0] rsa, input logic [4:0] rta, input logic [4:0] rda,
                       input logic we, input logic [4:0] wa, input logic [DATA_W-1:0] wd);
    @(negedge clk);
    rst = r; stall = s; flush = f; valid = v; ctrl = c;
    rs_data = rsd; rt_data = rtd; imm = im;
    rs_addr = rsa; rt_addr = rta; rd_addr = rda;
    wb_we = we; wb_addr = wa; wb_data = wd;
  endtask

  task automatic expect_out(input string nm, input logic v, input logic [CTRL_W-1:0] c,
                            input logic [DATA_W-1:0] rsd, input logic [DATA_W-1:0] rtd,
                            input logic [DATA_W-1:0] im, input logic [4:0] rsa,
                            input logic [4:0] rta, input logic [4:0] rda,
                            input logic [CNT_W-1:0] sc, input logic [CNT_W-1:0] fc);
    exp_q.push_back({v, c, rsd, rtd, im, rsa, rta, rda, sc, fc});
    name_q.push_back(nm);
  endtask

  // Scoreboard monitor
  initial begin
    logic [W-1:0] act, exp_v;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        act   = {valid_o, ctrl_o, rs_data_o, rt_data_o, imm_o,
                 rs_addr_o, rt_addr_o, rd_addr_o, stall_cnt_o, flush_cnt_o};
        n_vec++;
        if (act !== exp_v) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
      end
    end
  end

  initial begin
    rst = 0; stall = 0; flush = 0; valid = 0; ctrl = '0;
    rs_data = '0; rt_data = '0; imm = '0; rs_addr = '0; rt_addr = '0; rd_addr = '0;
    wb_we = 0; wb_addr = '0; wb_data = '0;

    drive(1, 1, 1, 1, 8'hFF, 32'hDEADBEEF, 32'h1, 32'h2, 5'd1, 5'd2, 5'd3, 1, 5'd1, 32'h9);
    expect_out("reset", 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);

    drive(0, 0, 0, 1, 8'h81, 32'h11, 32'h22, 32'hFFFFFFFC, 5'd3, 5'd4, 5'd5, 0, 5'd0, 32'h0);
    expect_out("load", 1, 8'h81, 32'h11, 32'h22, 32'hFFFFFFFC, 3, 4, 5, 0, 0);

    drive(0, 0, 0, 1, 8'hA4, 32'hAAAA0001, 32'hAAAA0002, 32'h10, 5'd6, 5'd7, 5'd9, 0, 5'd0, 32'h0);
    expect_out("load_a", 1, 8'hA4, 32'hAAAA0001, 32'hAAAA0002, 32'h10, 6, 7, 9, 0, 0);

    for (int k = 1; k <= 3; k++) begin
      drive(0, 1, 0, k[0], 8'h0F + 8'(k), 32'h5000 + k, 32'h6000 + k, 32'h70 + k,
            5'd6, 5'd6, 5'(k), 1, 5'd6, 32'hBAD0 + k);
      expect_out("stall_hold", 1, 8'hA4, 32'hAAAA0001, 32'hAAAA0002, 32'h10, 6, 7, 9,
                 4'(k), 0);
    end

    drive(0, 1, 1, 1, 8'h55, 32'h1, 32'h2, 32'h3, 5'd4, 5'd5, 5'd6, 0, 5'd0, 32'h0);
    expect_out("flush_over_stall", 0, 8'h00, 0, 0, 0, 0, 0, 0, 3, 1);

    drive(0, 0, 0, 1, 8'h80, 32'h0, 32'h55, 32'h0, 5'd8, 5'd8, 5'd8, 1, 5'd8, 32'hCAFE);
    expect_out("bypass_both", 1, 8'h80, 32'hCAFE, 32'hCAFE, 0, 8, 8, 8, 3, 1);

    drive(0, 0, 0, 1, 8'h80, 32'h1234, 32'h5678, 32'h0, 5'd0, 5'd0, 5'd2, 1, 5'd0, 32'hCAFE);
    expect_out("no_bypass_r0", 1, 8'h80, 32'h1234, 32'h5678, 0, 0, 0, 2, 3, 1);

    drive(0, 0, 0, 1, 8'h88, 32'h100, 32'h200, 32'h4, 5'd3, 5'd9, 5'd10, 1, 5'd9, 32'hBEEF);
    expect_out("bypass_rt_only", 1, 8'h88, 32'h100, 32'hBEEF, 32'h4, 3, 9, 10, 3, 1);

    drive(0, 0, 0, 1, 8'h88, 32'h300, 32'h400, 32'h5, 5'd9, 5'd1, 5'd11, 0, 5'd9, 32'h77);
    expect_out("no_bypass_we0", 1, 8'h88, 32'h300, 32'h400, 32'h5, 9, 1, 11, 3, 1);

    drive(0, 0, 0, 0, 8'hFF, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 0, 5'd0, 32'h0);
    expect_out("invalid_ctrl0", 0, 8'h00, 32'h1, 32'h2, 32'h3, 1, 2, 3, 3, 1);

    drive(0, 0, 1, 1, 8'h81, 32'h9, 32'h9, 32'h9, 5'd9, 5'd9, 5'd9, 1, 5'd9, 32'h1);
    expect_out("flush_alone", 0, 8'h00, 0, 0, 0, 0, 0, 0, 3, 2);

    for (int k = 1; k <= 20; k++) begin
      drive(0, 1, 0, 1, 8'hC3, 32'(k), 32'(k), 32'(k), 5'd7, 5'd7, 5'd7, 0, 5'd0, 32'h0);
      expect_out("stall_sat", 0, 8'h00, 0, 0, 0, 0, 0, 0,
                 (3 + k > 15) ? 4'hF : 4'(3 + k), 2);
    end

    drive(1, 1, 0, 1, 8'hC3, 32'h1, 32'h1, 32'h1, 5'd7, 5'd7, 5'd7, 0, 5'd0, 32'h0);
    expect_out("reset_mid_stall", 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);

    drive(0, 1, 0, 1, 8'hC3, 32'h1, 32'h1, 32'h1, 5'd7, 5'd7, 5'd7, 0, 5'd0, 32'h0);
    expect_out("stall_after_reset", 0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);

    for (int k = 1; k <= 17; k++) begin
      drive(0, 1, 1, 1, 8'h3C, 32'h2, 32'h2, 32'h2, 5'd4, 5'd4, 5'd4, 0, 5'd0, 32'h0);
      expect_out("flush_sat", 0, 8'h00, 0, 0, 0, 0, 0, 0, 1, (k > 15) ? 4'hF : 4'(k));
    end

    drive(0, 0, 0, 1, 8'h6A, 32'hF00D, 32'h0BAD, 32'h80000000, 5'd12, 5'd13, 5'd14,
          1, 5'd12, 32'h12345678);
    expect_out("load_after_flush", 1, 8'h6A, 32'h12345678, 32'h0BAD, 32'h80000000,
               12, 13, 14, 1, 15);

    drive(0, 0, 0, 0, 8'h00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
